emac_asym_dpram: RTL

Parametrised asymmetric dual-port buffer RAM for the Ethernet MAC datapath. The narrow port A faces the nibble-wide MII side, and the wide port B faces the bus side. It generalises the fixed 4/32-bit, 512-deep EMAC buffer in three ways: configurable widths, depth and output pipelining; per-byte write enables on the wide port; and defined cross-port collision behaviour. An optional post-reset clear engine zeroes the array before first use.

---
 rtl/emac_dpram_pkg.sv | 37 +++
 rtl/emac_dpram_clear_fsm.sv | 47 ++++
 rtl/emac_asym_dpram.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/emac_dpram_pkg.sv
// Shared types and width helpers for the asymmetric EMAC buffer RAM.
package emac_dpram_pkg;

    // Clear engine states: sweeping the array, or open for traffic.
    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } clear_state_e;

    // Ceiling log2; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        while ((64'd1 << res) < 64'(value)) res++;
        return res;
    endfunction

    function automatic int unsigned calc_ratio(input int unsigned narrow_w,
                                               input int unsigned wide_w);
        return wide_w / narrow_w;
    endfunction

    function automatic int unsigned calc_na_w(input int unsigned narrow_w,
                                              input int unsigned wide_w,
                                              input int unsigned depth);
        return clog2(depth * calc_ratio(narrow_w, wide_w));
    endfunction

    function automatic int unsigned calc_wa_w(input int unsigned depth);
        return clog2(depth);
    endfunction

    function automatic int unsigned calc_lanes(input int unsigned wide_w);
        return wide_w / 8;
    endfunction

endpackage

// File: rtl/emac_dpram_clear_fsm.sv
// Post-reset clear engine: walks every wide word once, writing zero, and holds
// busy high until the last word has been written.
module emac_dpram_clear_fsm
    import emac_dpram_pkg::*;
#(
    parameter int unsigned DEPTH = 512,
    parameter int unsigned WA_W  = calc_wa_w(DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            busy,
    output logic            clr_we,
    output logic [WA_W-1:0] clr_adr
);

    clear_state_e    state_q;
    logic [WA_W-1:0] adr_q;
    logic            busy_q;

    // Sweep one word per cycle from address 0, then park in READY until the next reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLEAR;
            adr_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            case (state_q)
                CLEAR: begin
                    adr_q <= adr_q + WA_W'(1);
                    if (adr_q == WA_W'(DEPTH - 1)) begin
                        state_q <= READY;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= READY;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign clr_we  = busy_q;
    assign clr_adr = adr_q;

endmodule

// File: rtl/emac_asym_dpram.sv
// Asymmetric dual-port buffer RAM: narrow port A (MII side), wide port B (bus side)
// with byte enables, cross-port write-first forwarding and optional output register.
// Define EMAC_DPRAM_CLEAR_EN to build the post-reset zeroing engine.
module emac_asym_dpram
    import emac_dpram_pkg::*;
#(
    parameter int unsigned NARROW_W = 4,
    parameter int unsigned WIDE_W   = 32,
    parameter int unsigned DEPTH    = 512,
    parameter int unsigned OUT_REG  = 0,
    localparam int unsigned RATIO   = calc_ratio(NARROW_W, WIDE_W),
    localparam int unsigned NA_W    = calc_na_w(NARROW_W, WIDE_W, DEPTH),
    localparam int unsigned WA_W    = calc_wa_w(DEPTH),
    localparam int unsigned LANES   = calc_lanes(WIDE_W),
    localparam int unsigned SL_W    = clog2(RATIO)
) (
    input  logic                Clk,
    input  logic                Rst_n,
    output logic                Busy,
    input  logic                Ce_a,
    input  logic                Wr_rd_n_a,
    input  logic [NA_W-1:0]     Adr_a,
    input  logic [NARROW_W-1:0] Data_in_a,
    output logic [NARROW_W-1:0] Data_out_a,
    output logic                Valid_a,
    input  logic                Ce_b,
    input  logic                Wr_rd_n_b,
    input  logic [LANES-1:0]    Be_b,
    input  logic [WA_W-1:0]     Adr_b,
    input  logic [WIDE_W-1:0]   Data_in_b,
    output logic [WIDE_W-1:0]   Data_out_b,
    output logic                Valid_b
);

    logic            busy;
    logic            clr_we;
    logic [WA_W-1:0] clr_adr;

`ifdef EMAC_DPRAM_CLEAR_EN
    emac_dpram_clear_fsm #(
        .DEPTH (DEPTH),
        .WA_W  (WA_W)
    ) u_clear_fsm (
        .clk     (Clk),
        .rst_n   (Rst_n),
        .busy    (busy),
        .clr_we  (clr_we),
        .clr_adr (clr_adr)
    );
`else
    assign busy    = 1'b0;
    assign clr_we  = 1'b0;
    assign clr_adr = '0;
`endif

    assign Busy = busy;

    logic wr_a, rd_a, wr_b, rd_b;
    assign wr_a = Ce_a & Wr_rd_n_a & ~busy;
    assign rd_a = Ce_a & ~Wr_rd_n_a & ~busy;
    assign wr_b = Ce_b & Wr_rd_n_b & ~busy;
    assign rd_b = Ce_b & ~Wr_rd_n_b & ~busy;

    logic [WIDE_W-1:0] mem [DEPTH];

    // Port A address split into wide word and little-endian slice offset.
    logic [WA_W-1:0]   word_a;
    logic [NA_W-1:0]   slice_a;
    logic [WIDE_W-1:0] aw_mask, aw_data, a_merged;
    assign word_a   = Adr_a[NA_W-1:SL_W];
    assign slice_a  = Adr_a & NA_W'(RATIO - 1);
    assign aw_mask  = WIDE_W'({NARROW_W{1'b1}}) << (slice_a * NARROW_W);
    assign aw_data  = WIDE_W'(Data_in_a) << (slice_a * NARROW_W);
    assign a_merged = (mem[word_a] & ~aw_mask) | (aw_data & aw_mask);

    logic              bw_en;
    logic [WA_W-1:0]   bw_adr;
    logic [LANES-1:0]  bw_be;
    logic [WIDE_W-1:0] bw_data, bw_mask, b_base, b_merged;
    logic              a_hit_b;

    // Port-B write mux: the clear engine owns the write port while it runs.
    always_comb begin
        bw_en   = wr_b;
        bw_adr  = Adr_b;
        bw_be   = Be_b;
        bw_data = Data_in_b;
        if (clr_we) begin
            bw_en   = 1'b1;
            bw_adr  = clr_adr;
            bw_be   = '1;
            bw_data = '0;
        end
    end

    // Expand byte enables into a bit mask.
    always_comb begin
        bw_mask = '0;
        for (int unsigned i = 0; i < LANES; i++) bw_mask[8*i +: 8] = {8{bw_be[i]}};
    end

    // On a same-word collision B's write is layered on top of A's merged word,
    // so B wins its enabled bytes and A keeps the rest of its slice.
    assign a_hit_b  = wr_a & bw_en & (word_a == bw_adr);
    assign b_base   = a_hit_b ? a_merged : mem[bw_adr];
    assign b_merged = (b_base & ~bw_mask) | (bw_data & bw_mask);

    // Array update; the collision word is written once, by the B path.
    always_ff @(posedge Clk) begin
        if (wr_a && !a_hit_b) mem[word_a] <= a_merged;
        if (bw_en) mem[bw_adr] <= b_merged;
    end

    // Cross-port write-first forwarding for reads.
    logic [WIDE_W-1:0]   fwd_a, fwd_b;
    logic [NARROW_W-1:0] rdata_a;
    assign fwd_a   = (bw_en && bw_adr == word_a) ? b_merged : mem[word_a];
    assign rdata_a = NARROW_W'(fwd_a >> (slice_a * NARROW_W));
    assign fwd_b   = (wr_a && word_a == Adr_b) ? a_merged : mem[Adr_b];

    logic [NARROW_W-1:0] data_a1;
    logic [WIDE_W-1:0]   data_b1;
    logic                valid_a1, valid_b1;

    // First read stage; data holds until the next read on that port.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            data_a1  <= '0;
            data_b1  <= '0;
            valid_a1 <= 1'b0;
            valid_b1 <= 1'b0;
        end else begin
            valid_a1 <= rd_a;
            valid_b1 <= rd_b;
            if (rd_a) data_a1 <= rdata_a;
            if (rd_b) data_b1 <= fwd_b;
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [NARROW_W-1:0] data_a2;
        logic [WIDE_W-1:0]   data_b2;
        logic                valid_a2, valid_b2;

        // Optional output stage, advancing only on a fresh first-stage result.
        always_ff @(posedge Clk or negedge Rst_n) begin
            if (!Rst_n) begin
                data_a2  <= '0;
                data_b2  <= '0;
                valid_a2 <= 1'b0;
                valid_b2 <= 1'b0;
            end else begin
                valid_a2 <= valid_a1;
                valid_b2 <= valid_b1;
                if (valid_a1) data_a2 <= data_a1;
                if (valid_b1) data_b2 <= data_b1;
            end
        end

        assign Data_out_a = data_a2;
        assign Valid_a    = valid_a2;
        assign Data_out_b = data_b2;
        assign Valid_b    = valid_b2;
    end else begin : g_no_out_reg
        assign Data_out_a = data_a1;
        assign Valid_a    = valid_a1;
        assign Data_out_b = data_b1;
        assign Valid_b    = valid_b1;
    end

endmodule
